// File: rtl/tt_sel_pkg.sv
// -----------------------------------------------------------------------------
// tt_sel_pkg
// Shared types and defaults for the Tiny Tapeout project-selection driver.
//   sel_state_t : sequencer FSM states
//   *_DEF       : default values for ADDR_W, RST_CYC and PULSE_CYC
//   tmr_w()     : width needed by the phase timer to hold the longest phase
// -----------------------------------------------------------------------------
package tt_sel_pkg;

   localparam int ADDR_W_DEF    = 10;
   localparam int RST_CYC_DEF   = 4;
   localparam int PULSE_CYC_DEF = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RST    = 3'd1,
      GAP    = 3'd2,
      INC_HI = 3'd3,
      INC_LO = 3'd4,
      ENA    = 3'd5
   } sel_state_t;

   // Enough bits to load the longer of the two phase lengths.
   function automatic int tmr_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tt_sel_timer.sv
// -----------------------------------------------------------------------------
// tt_sel_timer
// Loadable down-counter used to time every phase of the selection sequence.
// Loading N makes expire rise N-1 cycles later, so a phase entered on the
// loading edge lasts exactly N cycles when the FSM leaves on expire.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (has priority over counting)
//   load_val  : phase length in cycles (>= 1)
//   expire    : counter has reached zero (current phase ends this cycle)
// -----------------------------------------------------------------------------
module tt_sel_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (load)        cnt <= load_val - W'(1);
      else if (cnt != '0)   cnt <= cnt - W'(1);
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/tt_mux_sel_driver.sv
// -----------------------------------------------------------------------------
// tt_mux_sel_driver
// Drives the Tiny Tapeout mux selection interface from one address request:
// reset the mux address counter, pulse ctrl_sel_inc req_addr times, then
// raise ctrl_ena and pulse done.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid/ready : request handshake (ready only while idle)
//   req_addr        : project address, sampled on handshake
//   busy            : sequence in progress
//   done            : one-cycle pulse when ctrl_ena rises
//   cur_addr/valid  : last successfully selected address
//   ctrl_sel_rst_n  : mux address counter reset (active low)
//   ctrl_sel_inc    : mux address counter increment strobe
//   ctrl_ena        : selected project enable
// Build option: define TT_SEL_SKIP_EN to skip re-selecting the address that
// is already enabled (done pulses right after the handshake, no sel traffic).
// -----------------------------------------------------------------------------
module tt_mux_sel_driver
   import tt_sel_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int RST_CYC   = RST_CYC_DEF,
   parameter int PULSE_CYC = PULSE_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              cur_valid,
   output logic              ctrl_sel_rst_n,
   output logic              ctrl_sel_inc,
   output logic              ctrl_ena
);

   localparam int TW = tmr_w(RST_CYC, PULSE_CYC);

   sel_state_t        state;
   logic [ADDR_W-1:0] cnt;       // remaining inc pulses
   logic [ADDR_W-1:0] addr_q;    // address being selected
   logic              hs;
   logic              skip_hit;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_exp;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign hs        = req_valid && req_ready;

`ifdef TT_SEL_SKIP_EN
   assign skip_hit = (req_addr == cur_addr) && cur_valid && ctrl_ena;
`else
   assign skip_hit = 1'b0;
`endif

   // Timer is reloaded on every edge that enters a timed phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TW'(PULSE_CYC);
      case (state)
         IDLE: begin
            tmr_load = hs && !skip_hit;
            tmr_val  = TW'(RST_CYC);
         end
         RST, INC_HI:  tmr_load = tmr_exp;
         GAP, INC_LO:  tmr_load = tmr_exp && (cnt != '0);
         default:      tmr_load = 1'b0;
      endcase
   end

   tt_sel_timer #(.W(TW)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_exp)
   );

   // ENA has no dwell time: its actions are registered on the edge that
   // leaves GAP/INC_LO, and the FSM lands straight back in IDLE, so done
   // coincides with the first cycle a new request can be accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         addr_q         <= '0;
         done           <= 1'b0;
         cur_addr       <= '0;
         cur_valid      <= 1'b0;
         ctrl_sel_rst_n <= 1'b0;
         ctrl_sel_inc   <= 1'b0;
         ctrl_ena       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hs) begin
                  if (skip_hit) begin
                     done <= 1'b1;          // already enabled: report only
                  end else begin
                     addr_q         <= req_addr;
                     cnt            <= req_addr;
                     cur_valid      <= 1'b0;
                     ctrl_ena       <= 1'b0;
                     ctrl_sel_rst_n <= 1'b0;
                     ctrl_sel_inc   <= 1'b0;
                     state          <= RST;
                  end
               end
            end
            RST: begin
               if (tmr_exp) begin
                  ctrl_sel_rst_n <= 1'b1;
                  state          <= GAP;
               end
            end
            GAP, INC_LO: begin
               if (tmr_exp) begin
                  if (cnt != '0) begin
                     ctrl_sel_inc <= 1'b1;
                     state        <= INC_HI;
                  end else begin
                     ctrl_ena  <= 1'b1;
                     done      <= 1'b1;
                     cur_addr  <= addr_q;
                     cur_valid <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            INC_HI: begin
               if (tmr_exp) begin
                  ctrl_sel_inc <= 1'b0;
                  cnt          <= cnt - ADDR_W'(1);
                  state        <= INC_LO;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_mux_sel_driver.sv
// -----------------------------------------------------------------------------
// tb_tt_mux_sel_driver
// Scoreboard bench: stimulus pushes the expected completion of each request;
// a negedge monitor models the mux address counter, measures sel pulse timing
// and compares against the queue head whenever done pulses.
// -----------------------------------------------------------------------------
module tb_tt_mux_sel_driver;

   localparam int AW = 10;
   localparam int PC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          req_ready, busy, done, cur_valid;
   logic [AW-1:0] cur_addr;
   logic          ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

   tt_mux_sel_driver #(.ADDR_W(AW), .RST_CYC(4), .PULSE_CYC(PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .busy           (busy),
      .done           (done),
      .cur_addr       (cur_addr),
      .cur_valid      (cur_valid),
      .ctrl_sel_rst_n (ctrl_sel_rst_n),
      .ctrl_sel_inc   (ctrl_sel_inc),
      .ctrl_ena       (ctrl_ena)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int lat;      // cycles from handshake edge to done
      int pulses;   // inc pulses seen since handshake
      int rlen;     // cycles ctrl_sel_rst_n low since handshake
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Handshake bookkeeping at the active edge (reads pre-update values).
   int cyc = 0, hs_cyc = 0, hs_cnt = 0;
   always @(posedge clk) begin
      cyc++;
      if (!rst && req_valid && req_ready) begin
         hs_cyc = cyc;
         hs_cnt++;
      end
   end

   // Monitor: mux counter model, phase timing, scoreboard compare.
   int   seen_hs = 0, mux_cnt = 0, pulses = 0, rst_len = 0, hi_run = 0, lo_run = 0;
   bit   phase_bad = 1'b0;
   logic inc_q = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      if (rst) begin
         mux_cnt = 0; inc_q = 1'b0; hi_run = 0; lo_run = 0;
         if (done) chk("done_in_reset", 32'(done), 0);
      end else begin
         if (hs_cnt != seen_hs) begin
            seen_hs = hs_cnt; pulses = 0; rst_len = 0; phase_bad = 1'b0;
         end
         if (!ctrl_sel_rst_n) begin
            mux_cnt = 0; lo_run = 0;
            if (busy) rst_len++;
         end else if (ctrl_sel_inc && !inc_q) begin
            mux_cnt++; pulses++;
            if (lo_run != PC) phase_bad = 1'b1;
            hi_run = 1;
         end else if (ctrl_sel_inc) begin
            hi_run++;
         end else if (inc_q) begin
            if (hi_run != PC) phase_bad = 1'b1;
            lo_run = 1;
         end else begin
            lo_run++;
         end
         inc_q = ctrl_sel_inc;
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 0);
            end else begin
               e = sb.pop_front();
               chk("latency",   32'(cyc - hs_cyc), 32'(e.lat));
               chk("cur_addr",  32'(cur_addr),     32'(e.addr));
               chk("mux_model", 32'(mux_cnt),      32'(e.addr));
               chk("pulses",    32'(pulses),       32'(e.pulses));
               chk("rst_len",   32'(rst_len),      32'(e.rlen));
               chk("phase_w",   32'(phase_bad),    0);
               chk("cur_valid", 32'(cur_valid),    1);
               chk("ctrl_ena",  32'(ctrl_ena),     1);
               chk("ready_done",32'(req_ready),    1);
            end
         end
      end
   end

   task automatic issue(input int addr, input int lat, input int pul, input int rl);
      int i;
      for (i = 0; i < 200 && !req_ready; i++) @(negedge clk);
      if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
      sb.push_back('{addr, lat, pul, rl});
      req_valid = 1'b1;
      req_addr  = AW'(addr);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 32'(sb.size()), 0);
         sb.delete();
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sel_rst_n", 32'(ctrl_sel_rst_n), 0);
      chk("rst_sel_inc",   32'(ctrl_sel_inc),   0);
      chk("rst_ena",       32'(ctrl_ena),       0);
      chk("rst_ready",     32'(req_ready),      1);
      chk("rst_busy",      32'(busy),           0);
      chk("rst_done",      32'(done),           0);
      chk("rst_cur_valid", 32'(cur_valid),      0);
      chk("rst_cur_addr",  32'(cur_addr),       0);

      // addr=3: 4 + 2 + 3*4 = 18 cycles
      issue(3, 18, 3, 4);
      wait_done(100);

      // same address again while enabled
`ifdef TT_SEL_SKIP_EN
      issue(3, 0, 0, 0);
`else
      issue(3, 18, 3, 4);
`endif
      wait_done(100);

      // addr=0: no pulses, 6 cycles
      issue(0, 6, 0, 4);
      wait_done(100);

      // addr=1023: 6 + 4*1023 = 4098 cycles
      issue(1023, 4098, 1023, 4);
      wait_done(5000);

      // valid held through completion: addr 0 then 2 back to back
      sb.push_back('{0, 6, 0, 4});
      req_valid = 1'b1;
      req_addr  = AW'(0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (done) break;
      end
      req_addr = AW'(2);
      sb.push_back('{2, 14, 2, 4});
      @(negedge clk);
      req_valid = 1'b0;
      chk("held_accept", 32'(busy), 1);
      wait_done(100);

      // addr=5 with a competing request poked while busy
      issue(5, 26, 5, 4);
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      req_addr  = AW'(9);
      for (int i = 0; i < 3; i++) begin
         #1 chk("busy_ready", 32'(req_ready), 0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      wait_done(100);

      // addr=7 aborted by reset during an inc-high phase
      issue(7, 34, 7, 4);
      for (int i = 0; i < 100 && !ctrl_sel_inc; i++) @(negedge clk);
      chk("inc_seen", 32'(ctrl_sel_inc), 1);
      rst = 1'b1;
      #1;
      chk("abort_sel_rst_n", 32'(ctrl_sel_rst_n), 0);
      chk("abort_sel_inc",   32'(ctrl_sel_inc),   0);
      chk("abort_ena",       32'(ctrl_ena),       0);
      chk("abort_done",      32'(done),           0);
      chk("abort_cur_valid", 32'(cur_valid),      0);
      chk("abort_ready",     32'(req_ready),      1);
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_abort_valid", 32'(cur_valid), 0);
      chk("post_abort_ena",   32'(ctrl_ena),  0);

      // recovery after reset: addr=4 -> 22 cycles
      issue(4, 22, 4, 4);
      wait_done(100);

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
